// File: rtl/fetch_pkg.sv
// Shared types and constants for the multi-cycle instruction fetch stage.
// FETCH_ALIGN_CHECK_EN adds the FAULT state used for misaligned fetch requests.
package fetch_pkg;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3
    } fetch_state_t;
`endif

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int RS_MSB      = 25;
    localparam int RS_LSB      = 21;
    localparam int RT_MSB      = 20;
    localparam int RT_LSB      = 16;
    localparam int RD_MSB      = 15;
    localparam int RD_LSB      = 11;
    localparam int SHAMT_MSB   = 10;
    localparam int SHAMT_LSB   = 6;
    localparam int FUNCT_MSB   = 5;
    localparam int FUNCT_LSB   = 0;
    localparam int IMM_MSB     = 15;
    localparam int IMM_LSB     = 0;
    localparam int JTARGET_MSB = 25;
    localparam int JTARGET_LSB = 0;

    localparam int          WAIT_CNT_W       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicing of an instruction word into its decode fields.
// Shared between the fetch stage and downstream decode logic.
module instr_field_split
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jtarget
);

    assign opcode  = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs      = instr[RS_MSB:RS_LSB];
    assign rt      = instr[RT_MSB:RT_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign shamt   = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct   = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16   = instr[IMM_MSB:IMM_LSB];
    assign jtarget = instr[JTARGET_MSB:JTARGET_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, reads instruction memory with fixed latency, holds the IR.
// FETCH_ALIGN_CHECK_EN enables the sticky FAULT state for fetches from a misaligned PC.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    input  logic [31:0] mem_rdata,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jtarget,
    output logic        busy,
    output logic        fetch_done,
    output logic        misaligned
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(MEM_LATENCY - 1);

    fetch_state_t          state, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic [31:0]           pc_new, instr_new;
    logic                  capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            pc       <= RESET_PC;
            instr    <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            pc       <= pc_new;
            instr    <= instr_new;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        pc_new        = pc;
        instr_new     = instr;
        capture       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pc_load) begin
                    pc_new = pc_next;
                end
                if (fetch_start) begin
                    state_next = ST_ISSUE;
`ifdef FETCH_ALIGN_CHECK_EN
                    // Alignment is judged on the PC the fetch would actually use.
                    if (pc_new[1:0] != 2'b00) begin
                        state_next = ST_FAULT;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                wait_cnt_next = CNT_LOAD;
                if (MEM_LATENCY == 1) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt - 1'b1;
                if (wait_cnt <= 1) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (pc_load) begin
                    pc_new = pc_next;
                end
                state_next = ST_IDLE;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (capture) begin
            instr_new = mem_rdata;
            pc_new    = pc + PC_INCR;
        end
    end

    assign mem_rd     = (state == ST_ISSUE) || (state == ST_WAIT);
    assign busy       = mem_rd;
    assign fetch_done = (state == ST_DONE);
    assign mem_addr   = {pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (state == ST_FAULT);
`else
    assign misaligned = 1'b0;
`endif

    instr_field_split u_field_split (
        .instr   (instr),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm16   (imm16),
        .jtarget (jtarget)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, hand sequences and randomized fetches
// against a PC/IR model. Covers the FETCH_ALIGN_CHECK_EN fault path when that macro is defined.
module tb_instr_fetch_unit;

    localparam int          LAT    = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] mem_rdata;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic        busy;
    logic        fetch_done;
    logic        misaligned;

    instr_fetch_unit #(.MEM_LATENCY(LAT), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .mem_rdata   (mem_rdata),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .pc          (pc),
        .instr       (instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm16       (imm16),
        .jtarget     (jtarget),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;

    typedef struct {
        bit          ld;
        logic [31:0] tgt;
        logic [31:0] rdata;
        bit          noise;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [5:0]  exp_funct;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        pc_next     = '0;
        mem_rdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        m_pc    = RST_PC;
        m_instr = '0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
    task automatic fetch_seq(input bit ld, input logic [31:0] tgt, input logic [31:0] rdata,
                             input bit noise, input logic [31:0] exp_addr,
                             input logic [31:0] exp_pc, output int done_cyc);
        logic [LAT+2:0] rd_tr, done_tr, busy_tr;
        rd_tr    = '0;
        done_tr  = '0;
        busy_tr  = '0;
        done_cyc = -1;
        fetch_start = 1'b1;
        pc_load     = ld;
        pc_next     = tgt;
        mem_rdata   = $urandom;
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        pc_next     = $urandom;
        for (int i = 1; i <= LAT + 2; i++) begin
            @(negedge clk);
            rd_tr[i]   = mem_rd;
            done_tr[i] = fetch_done;
            busy_tr[i] = busy;
            if (i <= LAT) begin
                check("mem_addr", mem_addr, exp_addr);
                check("instr_hold", instr, m_instr);
            end
            if (i == LAT + 1) begin
                done_cyc = cyc;
                check("instr", instr, rdata);
                check("pc_after", pc, exp_pc);
                check("opcode", opcode, rdata >> 26);
                check("rs", rs, (rdata >> 21) & 32'h1F);
                check("rt", rt, (rdata >> 16) & 32'h1F);
                check("rd", rd, (rdata >> 11) & 32'h1F);
                check("shamt", shamt, (rdata >> 6) & 32'h1F);
                check("funct", funct, rdata & 32'h3F);
                check("imm16", imm16, rdata & 32'hFFFF);
                check("jtarget", jtarget, rdata & 32'h03FF_FFFF);
                check("misaligned_clear", misaligned, 1'b0);
            end
            mem_rdata = (i == LAT) ? rdata : $urandom;
            if (noise && i == LAT) begin
                pc_load     = 1'b1;
                pc_next     = 32'h0000_5550;
                fetch_start = 1'b1;
            end else begin
                pc_load     = 1'b0;
                fetch_start = 1'b0;
            end
        end
        check("mem_rd_trace", rd_tr, ((1 << LAT) - 1) << 1);
        check("busy_trace", busy_tr, ((1 << LAT) - 1) << 1);
        check("done_trace", done_tr, 1 << (LAT + 1));
        m_instr = rdata;
    endtask

    initial begin
        int          dc, prev;
        bit          ld, noise;
        logic [31:0] tgt, rdata, eff;
        int          ngap;

        // ld, tgt, rdata, noise, exp_addr, exp_pc, exp_funct, exp_rd
        tbl.push_back('{1'b0, 32'h0,         32'h0109_5020, 1'b0, 32'h0,         32'h4,         6'h20, 5'd10});
        tbl.push_back('{1'b0, 32'h0,         32'h0000_000D, 1'b0, 32'h4,         32'h8,         6'h0D, 5'd0});
        tbl.push_back('{1'b0, 32'h0,         32'h0000_0000, 1'b1, 32'h8,         32'hC,         6'h00, 5'd0});
        tbl.push_back('{1'b1, 32'h0000_0100, 32'h8C22_0004, 1'b0, 32'h100,       32'h104,       6'h04, 5'd0});
        tbl.push_back('{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 32'h0,         6'h3F, 5'd31});
        tbl.push_back('{1'b0, 32'h0,         32'h0274_8825, 1'b1, 32'h0,         32'h4,         6'h25, 5'd17});
`ifndef FETCH_ALIGN_CHECK_EN
        tbl.push_back('{1'b1, 32'h0000_0203, 32'h1234_5678, 1'b0, 32'h200,       32'h207,       6'h38, 5'd10});
`endif

        do_reset();
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instr, 32'h0);
        check("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
        check("rst_imm_jt", {imm16, jtarget}, 42'h0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", fetch_done, 1'b0);
        check("rst_misaligned", misaligned, 1'b0);
        check("rst_addr", mem_addr, RST_PC);

        // Reset during WAIT aborts the fetch with no capture.
        fetch_start = 1'b1;
        pc_load     = 1'b1;
        pc_next     = 32'h0000_0040;
        mem_rdata   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        @(negedge clk);
        check("abort_issue_rd", mem_rd, 1'b1);
        check("abort_issue_addr", mem_addr, 32'h40);
        @(negedge clk);
        check("abort_wait_rd", mem_rd, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("abort_rd_async", mem_rd, 1'b0);
        check("abort_pc", pc, RST_PC);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            bit seen_done;
            seen_done = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (fetch_done || mem_rd) seen_done = 1'b1;
                @(negedge clk);
            end
            check("abort_no_done", seen_done, 1'b0);
        end
        check("abort_instr", instr, 32'h0);
        check("abort_pc_idle", pc, RST_PC);
        m_pc    = RST_PC;
        m_instr = '0;

        prev = -1;
        foreach (tbl[k]) begin
            fetch_seq(tbl[k].ld, tbl[k].tgt, tbl[k].rdata, tbl[k].noise,
                      tbl[k].exp_addr, tbl[k].exp_pc, dc);
            check("tbl_funct", funct, tbl[k].exp_funct);
            check("tbl_rd", rd, tbl[k].exp_rd);
            if (k > 0) check("done_spacing", dc - prev, LAT + 2);
            prev = dc;
            m_pc = tbl[k].exp_pc;
        end

        // pc_load alone in IDLE and in DONE.
        pc_load = 1'b1;
        pc_next = 32'h0000_0800;
        @(negedge clk);
        pc_load = 1'b0;
        check("idle_load", pc, 32'h800);
        m_pc = 32'h800;

        for (int r = 0; r < 40; r++) begin
            ld    = ($urandom_range(0, 1) == 1);
            noise = ($urandom_range(0, 3) == 0);
            tgt   = $urandom;
            rdata = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            eff = ld ? tgt : m_pc;
            fetch_seq(ld, tgt, rdata, noise, eff & 32'hFFFF_FFFC, eff + 32'd4, dc);
            m_pc = eff + 32'd4;
            ngap = $urandom_range(0, 2);
            for (int g = 0; g < ngap; g++) begin
                if ($urandom_range(0, 1) == 1) begin
                    pc_load = 1'b1;
                    pc_next = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
                    pc_next[1:0] = 2'b00;
`endif
                    m_pc = pc_next;
                end
                @(negedge clk);
                pc_load = 1'b0;
            end
            check("rand_pc", pc, m_pc);
        end

`ifdef FETCH_ALIGN_CHECK_EN
        begin
            bit seen;
            pc_load = 1'b1;
            pc_next = 32'h0000_0102;
            @(negedge clk);
            pc_load = 1'b0;
            check("fault_pc_loaded", pc, 32'h102);
            fetch_start = 1'b1;
            @(negedge clk);
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (mem_rd || fetch_done || busy) seen = 1'b1;
                check("fault_misaligned", misaligned, 1'b1);
                fetch_start = 1'b1;
                pc_load     = 1'b1;
                pc_next     = 32'h0000_0200;
                @(negedge clk);
            end
            fetch_start = 1'b0;
            pc_load     = 1'b0;
            check("fault_no_access", seen, 1'b0);
            check("fault_pc_frozen", pc, 32'h102);
            check("fault_instr_frozen", instr, m_instr);
            do_reset();
            check("fault_reset_clear", misaligned, 1'b0);
            check("fault_reset_pc", pc, RST_PC);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch stage that sits directly upstream of the control unit. It owns the program counter, issues a read to instruction memory, and waits a fixed number of memory cycles. It then captures the word into the instruction register and presents decoded fields (opcode, funct, register indices, immediate) for the control unit to sequence on. A fetch is started by a one-cycle request; the stage returns a one-cycle done pulse.

## Interface
- MEM_LATENCY, 2: cycles `mem_rd` is held before `mem_rdata` is valid; legal range 1..15.
- RESET_PC, 32'h0000_0000: PC value after reset.
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- fetch_start  in  1  request one fetch; sampled only in IDLE.
- pc_load  in  1  load `pc_next` into PC; honoured only in IDLE and DONE.
- pc_next  in  32  branch/jump target.
- mem_rdata  in  32  instruction memory read data.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  32  memory address (= PC).
- pc  out  32  current program counter.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- imm16  out  16  instr[15:0].
- jtarget  out  26  instr[25:0].
- busy  out  1  high in ISSUE/WAIT.
- fetch_done  out  1  one-cycle pulse, IR updated.
- misaligned  out  1  alignment fault (see Configuration); tied 0 otherwise.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, FAULT (FAULT exists only with the macro).
- IDLE: `fetch_start`=1 → ISSUE. Otherwise stay in IDLE.
- ISSUE: `mem_rd`=1, `mem_addr`=pc. Load the wait counter with MEM_LATENCY-1. If MEM_LATENCY=1, capture at the end of this cycle and go to DONE; else go to WAIT.
- WAIT: `mem_rd`=1, address held, counter decrements. When counter reaches 0, capture at that edge and go to DONE.
- Capture edge: instr<=mem_rdata; pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
- DONE: `fetch_done`=1 for exactly one cycle, then IDLE. `fetch_start` in DONE is ignored; requester re-asserts in IDLE.
- `pc_load` in IDLE/DONE: pc<=pc_next at that edge. It is ignored in ISSUE/WAIT.
- `pc_load` and `fetch_start` in IDLE on the same edge: both honoured, and ISSUE presents the newly loaded pc.
- `fetch_start` while busy: ignored; no queueing.
- Decoded field outputs are pure slices of `instr`; they change only at the capture edge.

## Timing
- Reset values: state IDLE, pc=RESET_PC, instr=0, all fields 0, mem_rd=0, busy=0, fetch_done=0, misaligned=0.
- Reset mid-fetch aborts immediately: mem_rd drops asynchronously, no capture occurs, and pc returns to RESET_PC.
- Latency: `fetch_start` sampled at edge E0 → `mem_rd` high for MEM_LATENCY cycles starting after E0. Capture happens at edge E0+MEM_LATENCY, and `fetch_done` is high in cycle E0+MEM_LATENCY..E0+MEM_LATENCY+1.
- Total fetch period: MEM_LATENCY+2 cycles including return to IDLE.
- `mem_addr` is stable throughout ISSUE/WAIT; `mem_rdata` is sampled only at the capture edge.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: a fetch request in IDLE with pc[1:0]≠0 performs no memory access (mem_rd stays 0).
  - State goes to FAULT; `misaligned`=1 and stays set, FAULT is sticky, and pc/instr are frozen until reset.
  - `fetch_done` never pulses for that request.
- Not defined: no FAULT state and `misaligned` tied 0. `mem_addr` is presented as {pc[31:2],2'b00}, and pc increments by 4 from its loaded value.

## Structure
- Package `fetch_pkg`: the `fetch_state_t` enum, field bit-position constants (OPCODE_MSB/LSB, RS_MSB…, FUNCT_LSB), the default RESET_PC, and the PC increment constant 4.
- Sub-module `instr_field_split`: combinational slicing of `instr` into the field outputs. It is shared with later decode logic; FSM, counter and PC stay in the top.

## Test plan
- MEM_LATENCY=2, reset, `fetch_start` pulse, mem_rdata=32'h0109_5020 → mem_rd high 2 cycles at addr 0; then fetch_done=1, instr=32'h0109_5020, opcode=0, funct=6'h20, rd=10, pc=4.
- Back-to-back fetches with rdata 32'h0000_000D then 32'h0000_0000 → funct=6'h0D then 6'h00; pc goes 4 then 8; fetch_done pulses separated by 4 cycles.
- `pc_load`=1 with pc_next=32'h0000_0100 and `fetch_start` on the same IDLE edge → mem_addr=32'h100 in ISSUE; pc=32'h104 after capture.
- `pc_load` pulsed during WAIT → ignored; pc ends at old pc+4.
- Reset asserted during WAIT → mem_rd=0 immediately, pc=RESET_PC, instr unchanged at 0, no fetch_done.
- With FETCH_ALIGN_CHECK_EN: load pc=32'h0000_0102, then fetch → mem_rd stays 0, misaligned=1 held, later fetch_start ignored until reset.
